// File: rtl/interp_pkg.sv
// Shared types, widths, default prototype and FSM encoding for folded_polyphase_interp.
package interp_pkg;

  localparam int DATA_W        = 16;
  localparam int COEF_W        = 10;
  localparam int ACC_W         = 29;
  localparam int NTAPS_DEFAULT = 16;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Symmetric lowpass; even and odd taps each sum to 512 (unity DC gain per phase).
  localparam coef_t COEFS_DEFAULT [NTAPS_DEFAULT] = '{
    10'sd4,   10'sd8,   10'sd16,  10'sd34,  10'sd50,  10'sd100, 10'sd120, 10'sd180,
    10'sd180, 10'sd120, 10'sd100, 10'sd50,  10'sd34,  10'sd16,  10'sd8,   10'sd4
  };

endpackage

// File: rtl/interp_mul_16s_10s.sv
// Combinational full-precision signed multiplier shared by all taps and phases.
module interp_mul_16s_10s
  import interp_pkg::*;
#(
  parameter int A_W = DATA_W,
  parameter int B_W = COEF_W
) (
  input  logic signed [A_W-1:0]     i_a,
  input  logic signed [B_W-1:0]     i_b,
  output logic signed [A_W+B_W-1:0] o_p
);

  assign o_p = (A_W+B_W)'(i_a) * (A_W+B_W)'(i_b);

endmodule

// File: rtl/folded_polyphase_interp.sv
// Folded polyphase interpolator: one multiplier/accumulator computes L outputs per input.
// Build macro INTERP_SAT_EN: clamp outputs to the DATA_W range instead of wrapping.
module folded_polyphase_interp #(
  parameter int NTAPS     = 16,
  parameter int L         = 2,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 10,
  parameter int ACC_W     = 29,
  parameter int OUT_SHIFT = 9,
  parameter logic signed [COEF_W-1:0] COEFS [NTAPS] = interp_pkg::COEFS_DEFAULT
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready
);
  import interp_pkg::*;

  localparam int unsigned T = NTAPS / L;
  localparam int TAP_W  = (T > 1) ? $clog2(T) : 1;
  localparam int PH_W   = (L > 1) ? $clog2(L) : 1;
  localparam int IDX_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(2**(OUT_SHIFT-1));

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_x [T];
  logic signed [ACC_W-1:0]   r_acc;
  logic [TAP_W-1:0]          r_tap;
  logic [PH_W-1:0]           r_phase;
  logic signed [DATA_W-1:0]  r_m_data;
  logic                      r_live;

  logic [IDX_W-1:0]          w_idx;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [ACC_W:0]     w_rnd;
  logic signed [DATA_W-1:0]  w_out;
  logic                      w_accept;
  logic                      w_last_tap;
  logic                      w_last_phase;

  assign w_idx        = IDX_W'(int'(r_tap) * L + int'(r_phase));
  assign w_coef       = COEFS[w_idx];
  assign w_acc_next   = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_last_tap   = (r_tap == TAP_W'(T-1));
  assign w_last_phase = (r_phase == PH_W'(L-1));

  assign s_ready  = r_live && (r_state == ST_IDLE);
  assign w_accept = s_valid && s_ready;
  assign m_valid  = (r_state == ST_OUT);
  assign m_data   = r_m_data;

  interp_mul_16s_10s #(
    .A_W(DATA_W),
    .B_W(COEF_W)
  ) u_mul (
    .i_a(r_x[r_tap]),
    .i_b(w_coef),
    .o_p(w_prod)
  );

`ifdef INTERP_SAT_EN
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);
  logic signed [ACC_W:0] w_shf;

  always_comb begin
    w_rnd = {w_acc_next[ACC_W-1], w_acc_next} + RND;
    w_shf = w_rnd >>> OUT_SHIFT;
    w_out = w_shf[DATA_W-1:0];
    if (w_shf > SAT_MAX)      w_out = SAT_MAX[DATA_W-1:0];
    else if (w_shf < SAT_MIN) w_out = SAT_MIN[DATA_W-1:0];
  end
`else
  always_comb begin
    w_rnd = {w_acc_next[ACC_W-1], w_acc_next} + RND;
    w_out = DATA_W'(w_rnd >>> OUT_SHIFT);
  end
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_tap    <= '0;
      r_phase  <= '0;
      r_m_data <= '0;
      r_live   <= 1'b0;
      for (int unsigned i = 0; i < T; i++) r_x[i] <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x[0] <= s_data;
            for (int unsigned i = 1; i < T; i++) r_x[i] <= r_x[i-1];
            r_phase <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          // Output is formatted from the final sum so m_data is registered on OUT entry.
          if (w_last_tap) begin
            r_m_data <= w_out;
            r_state  <= ST_OUT;
          end else begin
            r_tap <= r_tap + TAP_W'(1);
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            if (!w_last_phase) begin
              r_phase <= r_phase + PH_W'(1);
              r_tap   <= '0;
              r_acc   <= '0;
              r_state <= ST_MAC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
